max_unpool: RTL and testbench
=============================

Name: max_unpool

Overview:
- Streaming 2x2 max-unpooling stage: the inverse of the pool/ max-pooling path.
- Accepts a pooled feature map in raster order. Each element is a signed value plus a 2-bit argmax index.
- Emits the full-resolution map (2x width, 2x height) in raster order. Each value is placed at its argmax position; the other three positions of its window are zero.
- Ping-pong row buffering lets the next pooled row fill while the current one drains.

Parameters:
- WIDTH, 9, bit width of the signed data value (matches the pooling datapath).
- POOL_W, 4, pooled-map row length in elements; output row length is 2*POOL_W. Legal values are 1 and up.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset. Asynchronous, active-high (1 = reset), despite the name.
- in_valid  input  1  pooled element present.
- in_ready  output  1  block can accept an element.
- in_data  input  WIDTH  signed pooled value.
- in_idx  input  2  argmax position in the 2x2 window. Bit 1 = row offset, bit 0 = column offset.
- out_valid  output  1  output element present.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  signed full-resolution element.
- out_eol  output  1  high with the last element (column 2*POOL_W-1) of each output row.

Behaviour:
- Transfers: an input transfer occurs when in_valid&&in_ready; an output transfer when out_valid&&out_ready. Once asserted, out_valid/out_data/out_eol hold stable until the transfer.
- Storage: two banks (B0, B1), each holding POOL_W entries of {value, idx}, and a full flag per bank.
- Write side: pointer wb and column counter wc (0..POOL_W-1).
  - in_ready = !full[wb].
  - On input transfer: store into bank wb at entry wc, then increment wc.
  - At wc==POOL_W-1: set full[wb], wc←0, toggle wb.
- Read side: pointer rb, sub-row counter rr (0/1), output column counter oc (0..2*POOL_W-1).
  - out_valid = full[rb].
  - Element used: e = bank rb entry oc>>1.
  - out_data = (e.idx == {rr, oc[0]}) ? e.value : 0.
  - out_eol = (oc == 2*POOL_W-1).
- Read advance on output transfer:
  - oc increments.
  - At oc==2*POOL_W-1: oc←0 and rr toggles.
  - If rr was 1: clear full[rb] and toggle rb.
- Simultaneous events: a fill-completion and a drain-completion in the same cycle act on different banks. Both updates apply in that cycle, with no lost or duplicated rows.
- Full-flag timing: a bank cleared by a drain is writable in the next cycle. in_ready is registered-flag based and does not combinationally depend on out_ready.
- Latency: out_valid rises the cycle after the input transfer that completes a row, if that bank is rb.
- Throughput:
  - Output sustains 1 element/cycle with out_ready=1.
  - 4 output elements per input element, so in_ready deasserts whenever both banks are full.
- Reset values: full=2'b00, wb=rb=0, wc=oc=rr=0. Hence out_valid=0, out_eol=0, out_data=0 (don't-care while out_valid=0), in_ready=1. Buffer contents need no reset.
- Reset mid-operation: all buffered rows and partial rows are discarded, and the next input is treated as column 0 of a new pooled row.
- Arithmetic: no arithmetic; values pass bit-exact, sign preserved. Zero fill is all-zero bits.
- No frame boundary signal: rows repeat indefinitely. The upstream side is responsible for frame alignment via reset.

Test Plan:
- POOL_W=2, out_ready=1, inputs (5,idx0),(-3,idx3) -> outputs 5,0,0,0 then 0,0,0,-3. out_eol on the 4th and 8th outputs only.
- POOL_W=2, inputs (-256,idx1),(255,idx2) -> row0: 0,-256,0,0; row1: 0,0,255,0. Extremes must be preserved exactly.
- Continuous in_valid=1, out_ready=1, 3 pooled rows -> row 2 fills during row 1 drain, and in_ready=0 while both banks are full.
  - Exactly 24 outputs, in order, with no gaps after the first valid.
- Random out_ready stalls with random in_valid over 50 rows -> output stream matches a reference model exactly.
  - Output holds stable while stalled; in_ready is never high when full[wb] is set.
- Same-cycle completion: the last input of a row and the last output of a row transfer in the same cycle -> both full flags update correctly, with no row lost or repeated.
- Assert rst_n=1 after 1 input and 3 outputs of a second row -> out_valid=0 and in_ready=1 immediately (asynchronous reset).
  - After release, (7,idx0),(1,idx0) yields 7,0,1,0 / 0,0,0,0.

Source files
------------

// File: rtl/max_unpool_if.sv
// Stream bundle for max_unpool: pooled {value, argmax} in, full-resolution elements out.
// slave is the unpooler's view; master is the upstream/downstream driver's view.
interface max_unpool_if #(
   parameter int WIDTH = 9
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] in_data;
   logic [1:0]              in_idx;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] out_data;
   logic                    out_eol;

   modport master (
      output in_valid, in_data, in_idx, out_ready,
      input  in_ready, out_valid, out_data, out_eol
   );

   modport slave (
      input  in_valid, in_data, in_idx, out_ready,
      output in_ready, out_valid, out_data, out_eol
   );
endinterface

// File: rtl/max_unpool.sv
// Streaming 2x2 max-unpool: a ping-pong pair of pooled-row banks, each row
// replayed as two full-resolution output rows with zeros off the argmax.
module max_unpool #(
   parameter int WIDTH  = 9,
   parameter int POOL_W = 4
) (
   input logic         clk,
   input logic         rst_n,   // active-high asynchronous reset
   max_unpool_if.slave io
);
   localparam int CW  = (POOL_W > 1) ? $clog2(POOL_W) : 1;
   localparam int OCW = $clog2(2 * POOL_W);
   localparam logic [CW-1:0]  WC_LAST = CW'(POOL_W - 1);
   localparam logic [OCW-1:0] OC_LAST = OCW'(2 * POOL_W - 1);

   typedef struct packed {
      logic signed [WIDTH-1:0] val;
      logic [1:0]              idx;
   } entry_t;

   entry_t         bank_q [2][POOL_W];
   logic [1:0]     full_q, full_d;
   logic           wb_q, wb_d;
   logic           rb_q, rb_d;
   logic           rr_q, rr_d;
   logic [CW-1:0]  wc_q, wc_d;
   logic [OCW-1:0] oc_q, oc_d;

   logic           in_rdy, out_vld;
   logic           in_fire, out_fire;
   logic [CW-1:0]  rd_col;
   entry_t         rd_e;

   assign in_rdy   = !full_q[wb_q];
   assign out_vld  = full_q[rb_q];
   assign in_fire  = io.in_valid && in_rdy;
   assign out_fire = out_vld && io.out_ready;

   // Each pooled entry covers two adjacent output columns.
   assign rd_col = CW'(oc_q >> 1);
   assign rd_e   = bank_q[rb_q][rd_col];

   assign io.in_ready  = in_rdy;
   assign io.out_valid = out_vld;
   assign io.out_eol   = (oc_q == OC_LAST);
   assign io.out_data  = (out_vld && (rd_e.idx == {rr_q, oc_q[0]})) ? rd_e.val : '0;

   always_comb begin
      full_d = full_q;
      wb_d   = wb_q;
      wc_d   = wc_q;
      rb_d   = rb_q;
      rr_d   = rr_q;
      oc_d   = oc_q;
      if (in_fire) begin
         if (wc_q == WC_LAST) begin
            full_d[wb_q] = 1'b1;
            wc_d         = '0;
            wb_d         = !wb_q;
         end else begin
            wc_d = wc_q + 1'b1;
         end
      end
      // A fill can only target a non-full bank and a drain only a full one,
      // so both flag updates in one cycle always hit different banks.
      if (out_fire) begin
         if (oc_q == OC_LAST) begin
            oc_d = '0;
            rr_d = !rr_q;
            if (rr_q) begin
               full_d[rb_q] = 1'b0;
               rb_d         = !rb_q;
            end
         end else begin
            oc_d = oc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         full_q <= '0;
         wb_q   <= 1'b0;
         rb_q   <= 1'b0;
         rr_q   <= 1'b0;
         wc_q   <= '0;
         oc_q   <= '0;
      end else begin
         full_q <= full_d;
         wb_q   <= wb_d;
         rb_q   <= rb_d;
         rr_q   <= rr_d;
         wc_q   <= wc_d;
         oc_q   <= oc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (in_fire) bank_q[wb_q][wc_q] <= '{val: io.in_data, idx: io.in_idx};
   end
endmodule

// File: tb/tb_max_unpool.sv
// Scoreboard bench for max_unpool (POOL_W=2): directed rows, back-to-back fill,
// random stalls, same-cycle fill/drain and asynchronous mid-stream reset.
module tb_max_unpool;
   localparam int WIDTH  = 9;
   localparam int POOL_W = 2;
   localparam int OW     = 2 * POOL_W;

   typedef struct {
      int d;
      bit eol;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   max_unpool_if #(.WIDTH(WIDTH)) io ();
   max_unpool #(.WIDTH(WIDTH), .POOL_W(POOL_W)) dut (
      .clk   (clk),
      .rst_n (rst),
      .io    (io.slave)
   );

   exp_t q[$];
   int   n_tests = 0, n_fail = 0;
   int   cyc = 0, xfer_total = 0, mark = 0, first_cyc = 0, last_cyc = 0;
   int   same_cnt = 0, block_cnt = 0, in_cnt = 0, out_cnt = 0;
   bit   hold_v = 0, hold_e = 0;
   int   hold_d = 0;
   bit   rdy_rand = 0, rdy_force = 1;
   logic signed [WIDTH-1:0] row_v [POOL_W];
   logic [1:0]              row_i [POOL_W];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic exp4(input int a, input int b, input int c, input int d);
      q.push_back(exp_t'{d: a, eol: 1'b0});
      q.push_back(exp_t'{d: b, eol: 1'b0});
      q.push_back(exp_t'{d: c, eol: 1'b0});
      q.push_back(exp_t'{d: d, eol: 1'b1});
   endtask

   // Reference: scatter each pooled value into a 2-row x OW grid at its argmax.
   task automatic push_model();
      int grid [2][OW];
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < OW; c++) grid[r][c] = 0;
      for (int j = 0; j < POOL_W; j++)
         grid[int'(row_i[j][1])][2*j + int'(row_i[j][0])] = int'(row_v[j]);
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < OW; c++) q.push_back(exp_t'{d: grid[r][c], eol: (c == OW-1)});
   endtask

   task automatic send(input int v, input logic [1:0] ix);
      int n = 0;
      bit ok = 0;
      io.in_valid = 1'b1;
      io.in_data  = WIDTH'(v);
      io.in_idx   = ix;
      do begin
         @(negedge clk);
         ok = io.in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 500);
      if (!ok) chk("send_timeout", n, 0);
      io.in_valid = 1'b0;
   endtask

   task automatic send_row(input int max_gap);
      for (int j = 0; j < POOL_W; j++) begin
         send(int'(row_v[j]), row_i[j]);
         repeat ($urandom_range(0, max_gap)) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic set_row(input int v0, input int i0, input int v1, input int i1);
      row_v[0] = WIDTH'(v0); row_i[0] = 2'(i0);
      row_v[1] = WIDTH'(v1); row_i[1] = 2'(i1);
   endtask

   task automatic wait_xfers(input int n);
      int k = 0;
      while (xfer_total - mark < n && k < 2000) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (xfer_total - mark < n) chk("xfer_wait_timeout", xfer_total - mark, n);
   endtask

   task automatic wait_drain();
      int k = 0;
      while ((q.size() != 0 || io.out_valid) && k < 3000) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("drain_queue_empty", q.size(), 0);
   endtask

   // out_ready is owned by this process alone; it updates just after each edge.
   initial begin
      io.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         io.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
      end
   end

   // Monitor: pops the scoreboard on every output transfer, checks hold and in_ready.
   always @(negedge clk) begin
      bit   in_f, out_f;
      int   rows;
      exp_t e;
      cyc++;
      if (rst) begin
         in_cnt = 0;
         out_cnt = 0;
         hold_v = 0;
      end else begin
         in_f  = io.in_valid && io.in_ready;
         out_f = io.out_valid && io.out_ready;
         rows  = in_cnt / POOL_W - out_cnt / (2*OW);
         chk("in_ready_vs_occupancy", int'(io.in_ready), int'(rows < 2));
         if (!io.in_ready) block_cnt++;
         if (hold_v) begin
            chk("hold_valid", int'(io.out_valid), 1);
            chk("hold_data", int'($signed(io.out_data)), hold_d);
            chk("hold_eol", int'(io.out_eol), int'(hold_e));
         end
         if (out_f) begin
            if (q.size() == 0) chk("unexpected_output_queue", q.size(), 1);
            else begin
               e = q.pop_front();
               chk("out_data", int'($signed(io.out_data)), e.d);
               chk("out_eol", int'(io.out_eol), int'(e.eol));
            end
            if (xfer_total == mark) first_cyc = cyc;
            last_cyc = cyc;
            xfer_total++;
            if (in_f && out_cnt % (2*OW) == 2*OW-1 && in_cnt % POOL_W == POOL_W-1) same_cnt++;
         end
         in_cnt  += int'(in_f);
         out_cnt += int'(out_f);
         hold_v = io.out_valid && !io.out_ready;
         hold_d = int'($signed(io.out_data));
         hold_e = io.out_eol;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      io.in_valid = 1'b0;
      io.in_data  = '0;
      io.in_idx   = '0;
      repeat (2) @(negedge clk);
      chk("reset_out_valid", int'(io.out_valid), 0);
      chk("reset_in_ready", int'(io.in_ready), 1);
      chk("reset_out_eol", int'(io.out_eol), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Directed: basic placement and eol.
      exp4(5, 0, 0, 0);
      exp4(0, 0, 0, -3);
      send(5, 2'd0);
      send(-3, 2'd3);
      wait_drain();

      // Directed: data extremes.
      exp4(0, -256, 0, 0);
      exp4(0, 0, 255, 0);
      send(-256, 2'd1);
      send(255, 2'd2);
      wait_drain();

      // Continuous: three rows back-to-back, output must be gap-free.
      mark = xfer_total;
      base = block_cnt;
      set_row(1, 0, 2, 1); push_model(); send_row(0);
      set_row(3, 2, 4, 3); push_model(); send_row(0);
      set_row(-5, 1, 6, 0); push_model(); send_row(0);
      wait_drain();
      chk("cont_output_count", xfer_total - mark, 24);
      chk("cont_no_gaps", last_cyc - first_cyc, 23);
      chk("cont_in_ready_blocked", int'(block_cnt - base > 0), 1);

      // Same-cycle fill completion and drain completion.
      mark = xfer_total;
      base = same_cnt;
      set_row(10, 2, -7, 1); push_model(); send_row(0);
      set_row(3, 0, -1, 3); push_model();
      send(int'(row_v[0]), row_i[0]);
      wait_xfers(7);
      send(int'(row_v[1]), row_i[1]);
      set_row(8, 1, -2, 2); push_model(); send_row(0);
      wait_drain();
      chk("same_cycle_seen", same_cnt - base, 1);
      chk("same_cycle_count", xfer_total - mark, 24);

      // Random stalls and input gaps over 50 rows.
      rdy_rand = 1;
      for (int r = 0; r < 50; r++) begin
         for (int j = 0; j < POOL_W; j++) begin
            row_v[j] = WIDTH'($urandom_range(0, 511));
            row_i[j] = 2'($urandom_range(0, 3));
         end
         push_model();
         send_row(2);
      end
      wait_drain();
      rdy_rand = 0;
      rdy_force = 1;
      repeat (2) @(posedge clk);
      #1;

      // Asynchronous reset with one row draining and one partial row buffered.
      mark = xfer_total;
      q.push_back(exp_t'{d: 9, eol: 1'b0});
      q.push_back(exp_t'{d: 0, eol: 1'b0});
      q.push_back(exp_t'{d: 0, eol: 1'b0});
      send(9, 2'd0);
      send(4, 2'd3);
      send(2, 2'd1);
      wait_xfers(3);
      rdy_force = 0;
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_reset_out_valid", int'(io.out_valid), 0);
      chk("async_reset_in_ready", int'(io.in_ready), 1);
      chk("async_reset_xfers", xfer_total - mark, 3);
      chk("async_reset_queue", q.size(), 0);
      q.delete();
      rdy_force = 1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      exp4(7, 0, 1, 0);
      exp4(0, 0, 0, 0);
      send(7, 2'd0);
      send(1, 2'd0);
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
